// File: rtl/fft_stage_seq_if.sv
// Handshake and status bundle for the FFT stage sequencer.
// The master drives the frame-valid strobe; the slave (the sequencer) returns
// per-stage enables, twiddle indices and frame status.
interface fft_stage_seq_if #(
  parameter int unsigned NUM_STAGES = 3
);

  logic                      in_valid;
  logic [NUM_STAGES-1:0]     stage_valid;
  logic [NUM_STAGES*5-1:0]   stage_idx;
  logic                      frame_done;
  logic                      busy;
  logic                      err_short;
  logic [7:0]                frame_cnt;

  modport master (
    output in_valid,
    input  stage_valid,
    input  stage_idx,
    input  frame_done,
    input  busy,
    input  err_short,
    input  frame_cnt
  );

  modport slave (
    input  in_valid,
    output stage_valid,
    output stage_idx,
    output frame_done,
    output busy,
    output err_short,
    output frame_cnt
  );

endinterface

// File: rtl/fft_stage_seq.sv
// Butterfly stage sequencer for a streaming FFT.
// Counts incoming samples into frames, carries {valid, idx, tag} down a shift
// pipeline and taps it once per stage to drive bfly/twiddle enables and the
// twiddle address. A short frame is cancelled by tag so an older, complete
// frame still in flight drains untouched.
module fft_stage_seq #(
  parameter int unsigned FRAME_LEN  = 32,
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned STAGE_LAT  = 2
) (
  input logic            clk,
  input logic            rstn,
  fft_stage_seq_if.slave bus
);

  localparam int unsigned      IDX_W    = 5;
  localparam int unsigned      DEPTH    = NUM_STAGES * STAGE_LAT;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] in_cnt_q, in_cnt_d;
  logic             tag_q, tag_d;

  logic             accept;
  logic             abort;
  logic [IDX_W-1:0] acc_idx;

  // Shift pipeline; entry 0 is written on the accepting edge.
  logic [DEPTH-1:0]            pv_q, pv_d, pv_live;
  logic [DEPTH-1:0]            ptag_q, ptag_d;
  logic [DEPTH-1:0][IDX_W-1:0] pidx_q, pidx_d;

  // Registered per-stage outputs, one tap each.
  logic [NUM_STAGES-1:0]            ov_q, ov_d;
  logic [NUM_STAGES-1:0][IDX_W-1:0] oidx_q, oidx_d;

  logic       done_q, done_d;
  logic       err_q;
  logic [7:0] cnt_q;

  // Frame FSM: decides acceptance, sample index, abort and next state.
  always_comb begin
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    tag_d    = tag_q;
    accept   = 1'b0;
    abort    = 1'b0;
    acc_idx  = in_cnt_q;

    unique case (state_q)
      StIdle: begin
        // The cycle that reports an abort never starts a new frame.
        if (bus.in_valid && !err_q) begin
          accept  = 1'b1;
          acc_idx = '0;
        end
      end
      StRun: begin
        if (bus.in_valid) begin
          accept = 1'b1;
        end else if (in_cnt_q != '0) begin
          abort = 1'b1;
        end else begin
          // Frame finished on the previous edge and no follow-on frame.
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          acc_idx = '0;
        end else if (!(|pv_q)) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (accept) begin
      state_d = StRun;
      if (acc_idx == LAST_IDX) begin
        // in_cnt of 0 in RUN marks a frame boundary, not a short frame.
        in_cnt_d = '0;
        tag_d    = ~tag_q;
      end else begin
        in_cnt_d = acc_idx + 1'b1;
      end
    end

    if (abort) begin
      state_d  = StIdle;
      in_cnt_d = '0;
    end
  end

  // Entry 0 of the pipeline takes the accepted sample with the current tag.
  always_comb begin
    pv_d[0]   = accept;
    pidx_d[0] = acc_idx;
    ptag_d[0] = tag_q;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_live
    // On abort, drop every entry carrying the aborted frame's tag.
    always_comb begin
      pv_live[i] = pv_q[i] & ~(abort & (ptag_q[i] == tag_q));
    end
  end

  for (genvar i = 1; i < DEPTH; i++) begin : g_shift
    // Plain shift of {valid, idx, tag} by one entry per cycle.
    always_comb begin
      pv_d[i]   = pv_live[i-1];
      pidx_d[i] = pidx_q[i-1];
      ptag_d[i] = ptag_q[i-1];
    end
  end

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_tap
    localparam int unsigned TAP = (s + 1) * STAGE_LAT - 1;

    // Stage output is the tap one entry before the stage boundary, registered.
    always_comb begin
      ov_d[s]   = pv_live[TAP];
      oidx_d[s] = pv_live[TAP] ? pidx_q[TAP] : '0;
    end

    assign bus.stage_idx[s*IDX_W +: IDX_W] = oidx_q[s];
  end

  // Frame completes when the last stage is about to emit the final index.
  always_comb begin
    done_d = ov_d[NUM_STAGES-1] && (oidx_d[NUM_STAGES-1] == LAST_IDX);
  end

  // State, pipeline and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= StIdle;
      in_cnt_q <= '0;
      tag_q    <= 1'b0;
      pv_q     <= '0;
      ptag_q   <= '0;
      pidx_q   <= '0;
      ov_q     <= '0;
      oidx_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      in_cnt_q <= in_cnt_d;
      tag_q    <= tag_d;
      pv_q     <= pv_d;
      ptag_q   <= ptag_d;
      pidx_q   <= pidx_d;
      ov_q     <= ov_d;
      oidx_q   <= oidx_d;
      done_q   <= done_d;
      err_q    <= abort;
      cnt_q    <= cnt_q + {7'd0, done_d};
    end
  end

  assign bus.stage_valid = ov_q;
  assign bus.frame_done  = done_q;
  assign bus.err_short   = err_q;
  assign bus.frame_cnt   = cnt_q;
  // Output registers are not counted: DRAIN ends as soon as the shift pipe empties.
  assign bus.busy        = (state_q != StIdle) | (|pv_q);

endmodule

// File: tb/tb_fft_stage_seq.sv
// Directed bench for fft_stage_seq: single frame, back-to-back frames, short
// frames, reset mid-frame and frame counter wrap.
module tb_fft_stage_seq;

  localparam int FL   = 32;
  localparam int NS   = 3;
  localparam int SL   = 2;
  localparam int NKILL = 32'h7fffffff;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  fft_stage_seq_if #(.NUM_STAGES(NS)) bus ();

  fft_stage_seq #(
    .FRAME_LEN (FL),
    .NUM_STAGES(NS),
    .STAGE_LAT (SL)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_cnt = 8'd0;

  // Expected {stage_valid, stage_idx} for a stream of 'count' samples accepted
  // on edges first..first+count-1, with everything removed from edge 'kill' on.
  function automatic logic [NS*6-1:0] stream(input int n, input int first, input int count,
                                             input int kill);
    logic [NS-1:0]   v;
    logic [NS*5-1:0] ix;
    v  = '0;
    ix = '0;
    for (int s = 0; s < NS; s++) begin
      int e;
      e = n - SL * (s + 1);
      if (e >= first && e < first + count && n < kill) begin
        v[s]         = 1'b1;
        ix[s*5 +: 5] = 5'((e - first) % FL);
      end
    end
    return {v, ix};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [28:0] observed();
    return {bus.stage_valid, bus.stage_idx, bus.frame_done, bus.busy, bus.err_short,
            bus.frame_cnt};
  endfunction

  task automatic test_reset();
    rstn         = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (bus.stage_valid !== 3'b000) begin
      n_bad++; $display("FAIL reset_stage_valid got=%b exp=000", bus.stage_valid);
    end
    n_cmp++;
    if (bus.stage_idx !== 15'd0) begin
      n_bad++; $display("FAIL reset_stage_idx got=%h exp=0", bus.stage_idx);
    end
    n_cmp++;
    if (bus.frame_done !== 1'b0) begin
      n_bad++; $display("FAIL reset_frame_done got=%b exp=0", bus.frame_done);
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy);
    end
    n_cmp++;
    if (bus.err_short !== 1'b0) begin
      n_bad++; $display("FAIL reset_err_short got=%b exp=0", bus.err_short);
    end
    n_cmp++;
    if (bus.frame_cnt !== 8'd0) begin
      n_bad++; $display("FAIL reset_frame_cnt got=%0d exp=0", bus.frame_cnt);
    end
    bus.in_valid = 1'b0;
    rstn         = 1'b1;
    exp_cnt      = 8'd0;
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_idle_busy got=%b exp=0", bus.busy);
    end
  endtask

  // One 32-sample frame starting at edge n=0.
  task automatic test_single_frame();
    logic [28:0]     exp;
    logic [NS*6-1:0] st;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 45; n++) begin
      tick();
      bus.in_valid = (n < FL - 1);
      if (n == 37) exp_cnt++;
      st  = stream(n, 0, FL, NKILL);
      exp = {st[NS*6-1 -: NS], st[NS*5-1:0], (n == 37), (n <= 37), 1'b0, exp_cnt};
      n_cmp++;
      if (observed() !== exp) begin
        n_bad++; $display("FAIL single n=%0d got=%h exp=%h", n, observed(), exp);
      end
    end
  endtask

  // Three frames with 96 continuous valid cycles.
  task automatic test_back_to_back();
    logic [28:0]     exp;
    logic [NS*6-1:0] st;
    logic            dn;
    int              pulses;
    pulses       = 0;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 110; n++) begin
      tick();
      bus.in_valid = (n < 3 * FL - 1);
      dn = (n >= 37) && (n <= 101) && ((n - 37) % 32 == 0);
      if (dn) exp_cnt++;
      if (bus.frame_done === 1'b1) pulses++;
      st  = stream(n, 0, 3 * FL, NKILL);
      exp = {st[NS*6-1 -: NS], st[NS*5-1:0], dn, (n <= 101), 1'b0, exp_cnt};
      n_cmp++;
      if (observed() !== exp) begin
        n_bad++; $display("FAIL back_to_back n=%0d got=%h exp=%h", n, observed(), exp);
      end
    end
    n_cmp++;
    if (pulses !== 3) begin
      n_bad++; $display("FAIL back_to_back_pulses got=%0d exp=3", pulses);
    end
  endtask

  // 10 samples then in_valid drops: abort on edge 10.
  task automatic test_short_frame();
    logic [28:0]     exp;
    logic [NS*6-1:0] st;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      bus.in_valid = (n < 9);
      st  = stream(n, 0, 10, 10);
      exp = {st[NS*6-1 -: NS], st[NS*5-1:0], 1'b0, (n <= 9), (n == 10), exp_cnt};
      n_cmp++;
      if (observed() !== exp) begin
        n_bad++; $display("FAIL short n=%0d got=%h exp=%h", n, observed(), exp);
      end
    end
  endtask

  // Full frame, 3 idle cycles, then a 5-sample frame aborted on edge 40.
  task automatic test_good_then_short();
    logic [28:0]     exp;
    logic [NS*6-1:0] st;
    int              errs;
    errs         = 0;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      tick();
      bus.in_valid = (n < FL - 1) || (n >= 34 && n <= 38);
      if (n == 37) exp_cnt++;
      if (bus.err_short === 1'b1) errs++;
      st  = stream(n, 0, FL, NKILL) | stream(n, 35, 5, 40);
      exp = {st[NS*6-1 -: NS], st[NS*5-1:0], (n == 37), (n <= 39), (n == 40), exp_cnt};
      n_cmp++;
      if (observed() !== exp) begin
        n_bad++; $display("FAIL good_short n=%0d got=%h exp=%h", n, observed(), exp);
      end
    end
    n_cmp++;
    if (errs !== 1) begin
      n_bad++; $display("FAIL good_short_err_pulses got=%0d exp=1", errs);
    end
  endtask

  // Reset with in_cnt=20, quiet afterwards, then a clean full frame.
  task automatic test_reset_mid();
    logic [28:0]     exp;
    logic [NS*6-1:0] st;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      st  = stream(n, 0, FL, NKILL);
      exp = {st[NS*6-1 -: NS], st[NS*5-1:0], 1'b0, 1'b1, 1'b0, exp_cnt};
      n_cmp++;
      if (observed() !== exp) begin
        n_bad++; $display("FAIL reset_mid_pre n=%0d got=%h exp=%h", n, observed(), exp);
      end
    end
    rstn         = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    exp_cnt = 8'd0;
    n_cmp++;
    if (observed() !== 29'd0) begin
      n_bad++; $display("FAIL reset_mid_clear got=%h exp=0", observed());
    end
    rstn = 1'b1;
    for (int n = 0; n < 12; n++) begin
      tick();
      n_cmp++;
      if (observed() !== 29'd0) begin
        n_bad++; $display("FAIL reset_mid_quiet n=%0d got=%h exp=0", n, observed());
      end
    end
    test_single_frame();
  endtask

  // 256 back-to-back frames: counter reaches 255 then wraps to 0.
  task automatic test_wrap();
    int pulses;
    pulses       = 0;
    rstn         = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    rstn         = 1'b1;
    exp_cnt      = 8'd0;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 8206; n++) begin
      tick();
      bus.in_valid = (n < 256 * FL - 1);
      if (bus.frame_done === 1'b1) pulses++;
      if (n == 8196) begin
        n_cmp++;
        if (bus.frame_cnt !== 8'd255) begin
          n_bad++; $display("FAIL wrap_pre got=%0d exp=255", bus.frame_cnt);
        end
      end
      if (n == 8197) begin
        n_cmp++;
        if ({bus.frame_done, bus.frame_cnt} !== {1'b1, 8'd0}) begin
          n_bad++; $display("FAIL wrap_zero got=%b/%0d exp=1/0", bus.frame_done, bus.frame_cnt);
        end
      end
    end
    n_cmp++;
    if (pulses !== 256) begin
      n_bad++; $display("FAIL wrap_pulses got=%0d exp=256", pulses);
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL wrap_busy_end got=%b exp=0", bus.busy);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_short_frame();
    test_good_then_short();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
